i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
- Single-transaction I2C bus master.
- After reset release it issues a START and sends a 7-bit slave address plus the R/W bit, then checks for the slave ACK.
- On ACK it either reads one byte from the slave into data_out or writes data_in to the slave, then issues a STOP and parks in DONE.
- It sits between system logic and the SCL/SDA pins; SDA is split into sda_in and sda_out, with the external open-drain pad handled outside this block.

Parameters:
- SLAVE_ADDR, default 7'h50, 7-bit target address sent MSB first.

Ports:
- clk  in  1  system clock; sclk runs at clk/2.
- rst  in  1  synchronous, active-low reset.
- rw  in  1  1 = read, 0 = write; sampled when leaving IDLE.
- data_in  in  8  byte to write; sampled when entering WRITING.
- data_out  out  8  byte read from the slave.
- state  out  3  current FSM state encoding.
- sclk  out  1  I2C clock.
- sda_in  in  1  SDA level driven by the slave/bus.
- sda_out  out  1  SDA level driven by the master; 1 = release/high.

Behaviour:
- All registers update on posedge clk.
- Reset (rst=0):
  - state=IDLE, sclk=1, sda_out=1, data_out=8'h00.
  - Bit counter and shift registers cleared.
  - Reset mid-transaction aborts immediately to these values; no STOP is generated.
- State encoding: IDLE=0, ADDRESSING=1, WAITING=2, READING=3, WRITING=4, DONE=5. Codes 6 and 7 go to IDLE.
- IDLE:
  - 1st cycle after reset release: sda_out←0 while sclk=1 (START); latch rw.
  - 2nd cycle: sclk←0, sda_out←address bit 6, state←ADDRESSING.
- Bit timing, all active states:
  - sclk toggles every clk cycle.
  - sda_out changes only on the cycle where sclk goes 1→0, so it is stable throughout every sclk-high phase.
  - sda_in is sampled on the clk edge at which sclk is 1.
- ADDRESSING:
  - 8 bits sent: SLAVE_ADDR[6:0] MSB first, then rw.
  - After the 8th bit's high phase, at sclk fall: sda_out←1 (release), state←WAITING.
- WAITING (ACK slot):
  - sda_in sampled during the sclk-high phase.
  - 0 = ACK: at the next sclk fall go to READING if rw=1, else WRITING.
  - 1 = NACK: STOP, then DONE.
- READING:
  - sda_out held 1.
  - 8 bits sampled LSB first: k-th sampled bit → data_out[k], k=0..7.
  - data_out is updated bit by bit and holds the full byte after the 8th sample.
  - Master then drives NACK (sda_out=1) for one sclk period, then STOP.
- WRITING:
  - data_in shifted out MSB first, 8 bits, same timing as ADDRESSING.
  - Then sda_out←1 and the slave ACK is sampled in one sclk-high phase; ACK/NACK only affects nothing beyond proceeding to STOP.
- STOP, 3 cycles:
  - sclk=0, sda_out=0.
  - sclk←1.
  - sda_out←1 (SDA rises while SCL high).
  - Then state←DONE.
- DONE:
  - sclk=1, sda_out=1, data_out held.
  - Remains until rst=0; no auto-restart.
- rw and data_in changes outside their sample points are ignored.

Decomposition:
- Shared package i2c_pkg: 3-bit state localparams (IDLE..DONE), bit-count constant 8.
- No sub-module required. Optional i2c_bit_shifter (8-bit load/shift with MSB/LSB-first select) is the natural split if reused.

Test Plan:
- Reset/START: hold rst=0 for 2 cycles, release → state=0, sclk=1, sda_out=1; next cycle sda_out=0 with sclk=1; following cycle state=1.
- Address frame, rw=1: bits captured on sclk-high read 1,0,1,0,0,0,0,1 (0x50 then R), then state=2 with sda_out=1.
- Read: slave ACKs (sda_in=0 for one high phase), then drives 0xF6 LSB first (0,1,1,0,1,1,1,1) → data_out=8'hF6, STOP seen (SDA 0→1 with sclk=1), state=5.
- Write: rw=0, data_in=8'hA5, slave ACKs address → sda_out bits on sclk-high read 1,0,1,0,0,1,0,1; ACK slot then STOP; state=5; data_out stays 8'h00.
- Address NACK: sda_in held 1 → no READING/WRITING entered, STOP then state=5, data_out=8'h00.
- Reset mid-READING, after 3 bits: rst=0 → next clk state=0, sclk=1, sda_out=1, data_out=8'h00.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the single-transaction I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDRESSING = 3'd1,
    ST_WAITING    = 3'd2,
    ST_READING    = 3'd3,
    ST_WRITING    = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  localparam int unsigned BIT_CNT  = 8;
  localparam logic [2:0]  LAST_BIT = 3'(BIT_CNT - 1);

endpackage

// File: rtl/i2c_master.sv
// Single-transaction I2C master: START, address+R/W, ACK check, one byte read
// or write, then STOP and park in DONE. sclk runs at clk/2.
module i2c_master
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] state,
  output logic       sclk,
  input  logic       sda_in,
  output logic       sda_out
);

  state_e     r_state, w_state_nxt;
  logic       r_sclk, w_sclk_nxt;
  logic       r_sda, w_sda_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_rw, w_rw_nxt;
  logic [1:0] r_step, w_step_nxt;
  // r_tail: final 9th clock after a byte (master NACK on read, slave ACK on write)
  logic       r_tail, w_tail_nxt;
  logic       r_stop, w_stop_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sclk  <= 1'b1;
      r_sda   <= 1'b1;
      r_data  <= 8'h00;
      r_shift <= 8'h00;
      r_cnt   <= 3'd0;
      r_rw    <= 1'b0;
      r_step  <= 2'd0;
      r_tail  <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sda   <= w_sda_nxt;
      r_data  <= w_data_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rw    <= w_rw_nxt;
      r_step  <= w_step_nxt;
      r_tail  <= w_tail_nxt;
      r_stop  <= w_stop_nxt;
    end
  end

  // STOP and the trailing ACK clock overlay the state that triggered them.
  always_comb begin
    w_state_nxt = r_state;
    w_sclk_nxt  = r_sclk;
    w_sda_nxt   = r_sda;
    w_data_nxt  = r_data;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_rw_nxt    = r_rw;
    w_step_nxt  = r_step;
    w_tail_nxt  = r_tail;
    w_stop_nxt  = r_stop;

    if (r_stop) begin
      case (r_step)
        2'd0: begin
          w_sclk_nxt = 1'b1;
          w_step_nxt = 2'd1;
        end
        2'd1: begin
          w_sda_nxt  = 1'b1;
          w_step_nxt = 2'd2;
        end
        default: begin
          w_state_nxt = ST_DONE;
          w_stop_nxt  = 1'b0;
          w_step_nxt  = 2'd0;
        end
      endcase
    end else if (r_tail) begin
      if (!r_sclk) begin
        w_sclk_nxt = 1'b1;
      end else begin
        w_sclk_nxt = 1'b0;
        w_sda_nxt  = 1'b0;
        w_tail_nxt = 1'b0;
        w_stop_nxt = 1'b1;
        w_step_nxt = 2'd0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_step == 2'd0) begin
            w_sda_nxt  = 1'b0;
            w_rw_nxt   = rw;
            w_step_nxt = 2'd1;
          end else begin
            w_sclk_nxt  = 1'b0;
            w_sda_nxt   = SLAVE_ADDR[6];
            w_shift_nxt = {SLAVE_ADDR[5:0], r_rw, 1'b0};
            w_cnt_nxt   = 3'd0;
            w_step_nxt  = 2'd0;
            w_state_nxt = ST_ADDRESSING;
          end
        end
        ST_ADDRESSING, ST_WRITING: begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_cnt == LAST_BIT) begin
              w_sda_nxt = 1'b1;
              w_cnt_nxt = 3'd0;
              if (r_state == ST_ADDRESSING) w_state_nxt = ST_WAITING;
              else                          w_tail_nxt  = 1'b1;
            end else begin
              w_sda_nxt   = r_shift[7];
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_cnt_nxt   = r_cnt + 3'd1;
            end
          end
        end
        ST_WAITING: begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            w_cnt_nxt  = 3'd0;
            if (sda_in) begin
              w_sda_nxt  = 1'b0;
              w_stop_nxt = 1'b1;
              w_step_nxt = 2'd0;
            end else if (r_rw) begin
              w_state_nxt = ST_READING;
              w_sda_nxt   = 1'b1;
            end else begin
              w_state_nxt = ST_WRITING;
              w_sda_nxt   = data_in[7];
              w_shift_nxt = {data_in[6:0], 1'b0};
            end
          end
        end
        ST_READING: begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt        = 1'b0;
            w_data_nxt[r_cnt] = sda_in;
            if (r_cnt == LAST_BIT) begin
              w_tail_nxt = 1'b1;
              w_cnt_nxt  = 3'd0;
            end else begin
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end
        end
        ST_DONE: begin
          w_sclk_nxt = 1'b1;
          w_sda_nxt  = 1'b1;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_sclk_nxt  = 1'b1;
          w_sda_nxt   = 1'b1;
          w_step_nxt  = 2'd0;
        end
      endcase
    end
  end

  assign data_out = r_data;
  assign state    = r_state;
  assign sclk     = r_sclk;
  assign sda_out  = r_sda;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a slave model answers each sclk-high
// phase while expected master SDA bits and read bytes come from scoreboards.
module tb_i2c_master;

  logic       clk;
  logic       rst;
  logic       rw;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [2:0] state;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic       exp_bits[$];
  logic [7:0] exp_data[$];

  i2c_master #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .state    (state),
    .sclk     (sclk),
    .sda_in   (sda_in),
    .sda_out  (sda_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset(input logic t_rw, input logic [7:0] t_din);
    rst     = 1'b0;
    rw      = t_rw;
    data_in = t_din;
    sda_in  = 1'b1;
    exp_bits.delete();
    exp_data.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  // Slave model + bus monitor; runs until DONE, the abort phase, or the budget.
  task automatic run_frame(input logic t_rw, input logic t_addr_ack, input logic [7:0] t_rd,
                           input int abort_ph, output bit stop_seen, output bit done_seen,
                           output bit rdwr_seen);
    int   ph;
    logic p_sclk, p_sda, exp_b;
    ph = -1; p_sclk = sclk; p_sda = sda_out;
    stop_seen = 0; done_seen = 0; rdwr_seen = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (state == 3'd5) begin
        done_seen = 1;
        break;
      end
      if (state == 3'd3 || state == 3'd4) rdwr_seen = 1;
      if (sclk && !p_sclk && state >= 3'd1 && state <= 3'd4) begin
        ph++;
        if (ph == abort_ph) break;
        if (ph == 8)                         sda_in = !t_addr_ack;
        else if (t_rw && ph >= 9 && ph <= 16) sda_in = t_rd[3'(ph - 9)];
        else if (!t_rw && ph == 17)          sda_in = 1'b0;
        else                                 sda_in = 1'b1;
        if (exp_bits.size() > 0) begin
          exp_b = exp_bits.pop_front();
          n_checks++;
          if (sda_out !== exp_b)
            $display("FAIL sda_bit[%0d]: got %b expected %b", ph, sda_out, exp_b);
          else n_pass++;
        end
      end
      if (p_sclk && sclk && !p_sda && sda_out) stop_seen = 1;
      p_sclk = sclk;
      p_sda  = sda_out;
    end
  endtask

  task automatic test_reset_start();
    apply_reset(1'b1, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 3'd0) $display("FAIL rst_state: got %0d expected 0", state); else n_pass++;
    n_checks++; if (sclk !== 1'b1) $display("FAIL rst_sclk: got %b expected 1", sclk); else n_pass++;
    n_checks++; if (sda_out !== 1'b1) $display("FAIL rst_sda: got %b expected 1", sda_out); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL rst_data: got %h expected 00", data_out); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (sda_out !== 1'b0) $display("FAIL start_sda: got %b expected 0", sda_out); else n_pass++;
    n_checks++; if (sclk !== 1'b1) $display("FAIL start_sclk: got %b expected 1", sclk); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL start_state: got %0d expected 0", state); else n_pass++;
    @(negedge clk);
    n_checks++; if (state !== 3'd1) $display("FAIL addr_state: got %0d expected 1", state); else n_pass++;
    n_checks++; if (sclk !== 1'b0) $display("FAIL addr_sclk: got %b expected 0", sclk); else n_pass++;
    n_checks++; if (sda_out !== 1'b1) $display("FAIL addr_bit6: got %b expected 1", sda_out); else n_pass++;
  endtask

  task automatic test_read(input logic [7:0] rd_byte);
    bit stop_seen, done_seen, rdwr_seen;
    apply_reset(1'b1, 8'h00);
    @(negedge clk);
    rw = 1'b0;
    push_byte({7'h50, 1'b1});
    exp_bits.push_back(1'b1);
    push_byte(8'hFF);
    exp_bits.push_back(1'b1);
    exp_data.push_back(rd_byte);
    run_frame(1'b1, 1'b1, rd_byte, -1, stop_seen, done_seen, rdwr_seen);
    n_checks++; if (!done_seen) $display("FAIL rd_done: timeout, state=%0d expected 5", state); else n_pass++;
    n_checks++; if (!stop_seen) $display("FAIL rd_stop: got 0 expected 1"); else n_pass++;
    n_checks++; if (data_out !== exp_data[0]) $display("FAIL rd_data: got %h expected %h", data_out, exp_data[0]); else n_pass++;
    void'(exp_data.pop_front());
    n_checks++; if (exp_bits.size() != 0) $display("FAIL rd_bits_left: got %0d expected 0", exp_bits.size()); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (state !== 3'd5) $display("FAIL rd_park: got %0d expected 5", state); else n_pass++;
    n_checks++; if ({sclk, sda_out} !== 2'b11) $display("FAIL rd_idle_bus: got %b expected 11", {sclk, sda_out}); else n_pass++;
    n_checks++; if (data_out !== rd_byte) $display("FAIL rd_hold: got %h expected %h", data_out, rd_byte); else n_pass++;
  endtask

  task automatic test_write(input logic [7:0] wr_byte);
    bit stop_seen, done_seen, rdwr_seen;
    apply_reset(1'b0, wr_byte);
    push_byte({7'h50, 1'b0});
    exp_bits.push_back(1'b1);
    push_byte(wr_byte);
    exp_bits.push_back(1'b1);
    exp_data.push_back(8'h00);
    run_frame(1'b0, 1'b1, 8'h00, -1, stop_seen, done_seen, rdwr_seen);
    n_checks++; if (!done_seen) $display("FAIL wr_done: timeout, state=%0d expected 5", state); else n_pass++;
    n_checks++; if (!stop_seen) $display("FAIL wr_stop: got 0 expected 1"); else n_pass++;
    n_checks++; if (data_out !== exp_data[0]) $display("FAIL wr_data_out: got %h expected %h", data_out, exp_data[0]); else n_pass++;
    void'(exp_data.pop_front());
    n_checks++; if (exp_bits.size() != 0) $display("FAIL wr_bits_left: got %0d expected 0", exp_bits.size()); else n_pass++;
  endtask

  task automatic test_addr_nack();
    bit stop_seen, done_seen, rdwr_seen;
    apply_reset(1'b1, 8'h00);
    push_byte({7'h50, 1'b1});
    exp_bits.push_back(1'b1);
    run_frame(1'b1, 1'b0, 8'h00, -1, stop_seen, done_seen, rdwr_seen);
    n_checks++; if (!done_seen) $display("FAIL nack_done: timeout, state=%0d expected 5", state); else n_pass++;
    n_checks++; if (!stop_seen) $display("FAIL nack_stop: got 0 expected 1"); else n_pass++;
    n_checks++; if (rdwr_seen) $display("FAIL nack_rdwr: got 1 expected 0"); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL nack_data: got %h expected 00", data_out); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    bit stop_seen, done_seen, rdwr_seen;
    apply_reset(1'b1, 8'h00);
    push_byte({7'h50, 1'b1});
    exp_bits.push_back(1'b1);
    repeat (3) exp_bits.push_back(1'b1);
    run_frame(1'b1, 1'b1, 8'hFF, 12, stop_seen, done_seen, rdwr_seen);
    n_checks++; if (state !== 3'd3) $display("FAIL mid_state: got %0d expected 3", state); else n_pass++;
    n_checks++; if (data_out !== 8'h07) $display("FAIL mid_partial: got %h expected 07", data_out); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 3'd0) $display("FAIL mid_rst_state: got %0d expected 0", state); else n_pass++;
    n_checks++; if ({sclk, sda_out} !== 2'b11) $display("FAIL mid_rst_bus: got %b expected 11", {sclk, sda_out}); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL mid_rst_data: got %h expected 00", data_out); else n_pass++;
    rst = 1'b1;
    sda_in = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rw = 1'b0; data_in = 8'h00; sda_in = 1'b1;
    test_reset_start();
    test_read(8'hF6);
    test_write(8'hA5);
    test_addr_nack();
    test_reset_mid_read();
    test_read(8'h81);
    test_write(8'h3C);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
